mux_pipelined: RTL and testbench

//  Parametrised N:1 word mux built as a RADIX-ary tree with valid/ready pipeline registers between tree levels.

---
 rtl/common_pkg.sv | 21 ++
 rtl/mux.sv | 18 +
 rtl/mux_pipe_stage.sv | 39 +++
 rtl/mux_pipelined.sv | 92 +++++++++
 tb/tb_mux_pipelined.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared datapath constants and helpers for the mux/NoC blocks.
package common_pkg;

    localparam int DEFAULT_D_W = 32;

    // Number of radix-ary levels needed to cover n leaves, never less than 1.
    function automatic int clog_radix(input int n, input int radix);
        int lv;
        longint span;
        lv = 0;
        span = 1;
        if (radix < 2) return 1;
        while (span < longint'(n)) begin
            span = span * radix;
            lv++;
        end
        if (lv < 1) lv = 1;
        return lv;
    endfunction

endpackage

// File: rtl/mux.sv
// Generic combinational N:1 word mux; out-of-range select yields zero.
module mux #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic [N-1:0][W-1:0]     i,
    input  logic [$clog2(N)-1:0]    s,
    output logic [W-1:0]            o
);

    always_comb begin
        o = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(s) == k) o = i[k];
        end
    end

endmodule

// File: rtl/mux_pipe_stage.sv
// One valid/ready register slice carrying data and select.
module mux_pipe_stage #(
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [W-1:0]  up_data,
    input  logic [SW-1:0] up_sel,
    output logic          up_ready,
    output logic          dn_valid,
    output logic [W-1:0]  dn_data,
    output logic [SW-1:0] dn_sel,
    input  logic          dn_ready
);

    logic v;

    // An empty slot, or one draining this cycle, can take a new word.
    assign up_ready = !v || dn_ready;
    assign dn_valid = v;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
        end else if (up_ready) begin
            v <= up_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (up_ready) begin
            dn_data <= up_data;
            dn_sel  <= up_sel;
        end
    end

endmodule

// File: rtl/mux_pipelined.sv
// N:1 word mux as a radix-2/4 tree with valid/ready registers between levels.
module mux_pipelined
    import common_pkg::*;
#(
    parameter int N         = 3,
    parameter int W         = DEFAULT_D_W,
    parameter int RADIX     = 4,
    parameter int REG_EVERY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(N)-1:0]     s,
    input  logic [N-1:0][W-1:0]      i,
    input  logic                     i_valid,
    output logic                     i_ready,
    output logic [W-1:0]             o,
    output logic [$clog2(N)-1:0]     o_sel,
    output logic                     o_valid,
    input  logic                     o_ready
);

    localparam int L      = $clog2(N);
    localparam int LEVELS = clog_radix(N, RADIX);
    localparam int STAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;
    localparam int DB     = (RADIX == 4) ? 2 : 1;
    localparam int SW     = LEVELS * DB;
    localparam int NP     = RADIX ** LEVELS;

    if (RADIX != 2 && RADIX != 4) begin : g_bad_radix
        $error("mux_pipelined: RADIX must be 2 or 4");
    end

    logic [NP-1:0][W-1:0] sd [STAGES+1];
    logic [SW-1:0]        ss [STAGES+1];
    logic                 sv [STAGES+1];
    logic                 rdy [1:STAGES+1];

    // Leaves beyond N read as zero, so s >= N selects zero.
    assign sd[0] = (NP*W)'(i);
    assign ss[0] = SW'(s);
    assign sv[0] = i_valid;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int G  = k / REG_EVERY;
        localparam int NG = NP / (RADIX ** (k + 1));

        logic [NP-1:0][W-1:0] li;
        logic [NP-1:0][W-1:0] lout;

        if (k % REG_EVERY == 0) begin : g_from_reg
            assign li = sd[G];
        end else begin : g_from_lvl
            assign li = g_lvl[k-1].lout;
        end

        for (genvar g = 0; g < NG; g++) begin : g_mux
            mux #(.N(RADIX), .W(W)) u_mux (
                .i (li[g*RADIX +: RADIX]),
                .s (ss[G][k*DB +: DB]),
                .o (lout[g])
            );
        end

        if (NG < NP) begin : g_pad
            assign lout[NP-1:NG] = '0;
        end

        if ((k % REG_EVERY == REG_EVERY - 1) || (k == LEVELS - 1)) begin : g_reg
            mux_pipe_stage #(.W(NP*W), .SW(SW)) u_stage (
                .clk      (clk),
                .rst      (rst),
                .up_valid (sv[G]),
                .up_data  (lout),
                .up_sel   (ss[G]),
                .up_ready (rdy[G+1]),
                .dn_valid (sv[G+1]),
                .dn_data  (sd[G+1]),
                .dn_sel   (ss[G+1]),
                .dn_ready (rdy[G+2])
            );
        end
    end

    assign rdy[STAGES+1] = o_ready;
    assign i_ready = rdy[1];

    // No output transfer may happen in a reset cycle.
    assign o_valid = sv[STAGES] && !rst;
    assign o       = sd[STAGES][0];
    assign o_sel   = ss[STAGES][L-1:0];

endmodule

// File: tb/tb_mux_pipelined.sv
// Directed and scoreboarded checks of mux_pipelined at several tree shapes.
module tb_mux_pipelined;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // A: N=16 RADIX=2 REG_EVERY=1 -> 4 stages
    logic [3:0]        a_s = '0;
    logic [15:0][7:0]  a_i = '0;
    logic              a_iv = 1'b0, a_ir, a_ov, a_or = 1'b1;
    logic [7:0]        a_o;
    logic [3:0]        a_osel;

    // B: N=5 RADIX=4 REG_EVERY=2 -> 1 stage, partial group
    logic [2:0]        b_s = '0;
    logic [4:0][7:0]   b_i = '0;
    logic              b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1;
    logic [7:0]        b_o;
    logic [2:0]        b_osel;

    // C: N=3 RADIX=4 REG_EVERY=1 -> 1 stage
    logic [1:0]        c_s = '0;
    logic [2:0][7:0]   c_i = '0;
    logic              c_iv = 1'b0, c_ir, c_ov, c_or = 1'b1;
    logic [7:0]        c_o;
    logic [1:0]        c_osel;

    mux_pipelined #(.N(16), .W(8), .RADIX(2), .REG_EVERY(1)) u_a (
        .clk(clk), .rst(rst), .s(a_s), .i(a_i), .i_valid(a_iv),
        .i_ready(a_ir), .o(a_o), .o_sel(a_osel), .o_valid(a_ov),
        .o_ready(a_or));

    mux_pipelined #(.N(5), .W(8), .RADIX(4), .REG_EVERY(2)) u_b (
        .clk(clk), .rst(rst), .s(b_s), .i(b_i), .i_valid(b_iv),
        .i_ready(b_ir), .o(b_o), .o_sel(b_osel), .o_valid(b_ov),
        .o_ready(b_or));

    mux_pipelined #(.N(3), .W(8), .RADIX(4), .REG_EVERY(1)) u_c (
        .clk(clk), .rst(rst), .s(c_s), .i(c_i), .i_valid(c_iv),
        .i_ready(c_ir), .o(c_o), .o_sel(c_osel), .o_valid(c_ov),
        .o_ready(c_or));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard for instance A
    logic [7:0] q_d [$];
    logic [3:0] q_s [$];
    logic       hold = 1'b0;
    logic [7:0] hold_o;
    logic [3:0] hold_sel;
    int t = 0;
    int nfire = 0, first_fire = -1, last_fire = -1, nacc = 0;

    // Inputs were driven at this negedge; evaluate what the next posedge does.
    task automatic a_eval();
        logic [7:0] d;
        logic [3:0] sl;
        #1;
        if (hold) begin
            chk("a_hold_v", 32'(a_ov), 32'd1);
            chk("a_hold_o", {20'd0, a_osel, a_o}, {20'd0, hold_sel, hold_o});
        end
        chk("a_iready", 32'(a_ir), 32'(!(q_d.size() == 4 && !a_or)));
        if (a_ov && a_or) begin
            if (q_d.size() == 0) begin
                chk("a_extra", 32'd1, 32'd0);
            end else begin
                d  = q_d.pop_front();
                sl = q_s.pop_front();
                chk("a_data", {20'd0, a_osel, a_o}, {20'd0, sl, d});
            end
            if (first_fire < 0) first_fire = t;
            last_fire = t;
            nfire++;
        end
        hold = a_ov && !a_or;
        hold_o = a_o;
        hold_sel = a_osel;
        if (a_iv && a_ir) begin
            q_d.push_back(a_i[a_s]);
            q_s.push_back(a_s);
            nacc++;
        end
        @(negedge clk);
        t++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ts;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_a_ov", 32'(a_ov), 32'd0);
        chk("rst_a_ir", 32'(a_ir), 32'd1);
        chk("rst_b_ov", 32'(b_ov), 32'd0);
        chk("rst_c_ov", 32'(c_ov), 32'd0);
        chk("rst_c_ir", 32'(c_ir), 32'd1);

        // C: single beat s=2 -> third word
        @(negedge clk);
        c_i = {8'h0C, 8'h0B, 8'h0A};
        c_s = 2'd2;
        c_iv = 1'b1;
        #1;
        chk("c_pre_ov", 32'(c_ov), 32'd0);
        @(negedge clk);
        c_iv = 1'b0;
        #1;
        chk("c_ov", 32'(c_ov), 32'd1);
        chk("c_o", 32'(c_o), 32'h0C);
        chk("c_osel", 32'(c_osel), 32'd2);
        @(negedge clk);
        #1;
        chk("c_pulse", 32'(c_ov), 32'd0);

        // B: partial group, latency 1, back-to-back
        @(negedge clk);
        b_i = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        b_s = 3'd4;
        b_iv = 1'b1;
        @(negedge clk);
        b_s = 3'd6;
        #1;
        chk("b_ov4", 32'(b_ov), 32'd1);
        chk("b_o4", {24'd0, b_osel, b_o[4:0]} & 32'h0, 32'h0);
        chk("b_o4d", 32'(b_o), 32'h55);
        chk("b_sel4", 32'(b_osel), 32'd4);
        @(negedge clk);
        b_s = 3'd0;
        #1;
        chk("b_o6", 32'(b_o), 32'h00);
        chk("b_sel6", 32'(b_osel), 32'd6);
        @(negedge clk);
        b_iv = 1'b0;
        #1;
        chk("b_o0", 32'(b_o), 32'h11);
        chk("b_ir", 32'(b_ir), 32'd1);
        @(negedge clk);
        #1;
        chk("b_done", 32'(b_ov), 32'd0);

        // A: stream s=0..15, i[k]=k*0x11, o_ready held high
        @(negedge clk);
        for (int k = 0; k < 16; k++) a_i[k] = 8'(k * 8'h11);
        a_or = 1'b1;
        nfire = 0;
        first_fire = -1;
        ts = t;
        for (int k = 0; k < 16; k++) begin
            a_s = 4'(k);
            a_iv = 1'b1;
            #0;
            chk("a_stream_ir", 32'(a_ir), 32'd1);
            a_eval();
        end
        a_iv = 1'b0;
        for (int k = 0; k < 8; k++) a_eval();
        chk("a_latency", 32'(first_fire - ts), 32'd4);
        chk("a_beats", 32'(nfire), 32'd16);
        chk("a_back2back", 32'(last_fire - first_fire), 32'd15);

        // A: random backpressure over 1000 accepted beats
        nacc = 0;
        for (int k = 0; k < 6000 && nacc < 1000; k++) begin
            a_or = 1'($urandom_range(0, 1));
            a_iv = ($urandom_range(0, 9) < 7);
            a_s = 4'($urandom);
            for (int j = 0; j < 16; j++) a_i[j] = 8'($urandom);
            a_eval();
        end
        chk("a_bp_bound", 32'(nacc >= 1000), 32'd1);
        a_iv = 1'b0;
        a_or = 1'b1;
        for (int k = 0; k < 8; k++) a_eval();
        chk("a_drain", 32'(q_d.size()), 32'd0);

        // A: fill the pipe, then reset for one cycle
        a_or = 1'b0;
        a_iv = 1'b1;
        for (int k = 0; k < 10 && a_ir; k++) a_eval();
        #1;
        chk("a_full", 32'(a_ir), 32'd0);
        rst = 1'b1;
        a_iv = 1'b0;
        a_or = 1'b1;
        #1;
        chk("a_rst_cyc_ov", 32'(a_ov), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("a_post_rst_ov", 32'(a_ov), 32'd0);
        chk("a_post_rst_ir", 32'(a_ir), 32'd1);
        q_d.delete();
        q_s.delete();
        hold = 1'b0;
        nfire = 0;
        for (int k = 0; k < 8; k++) a_eval();
        chk("a_no_stale", 32'(nfire), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
